fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage_pc_reg.sv | 19 +
 rtl/fetch_stage.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage: FSM encodings, NOP word, PC alignment helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FS_FETCH  = 2'd0,
    FS_HOLD   = 2'd1,
    FS_SQUASH = 2'd2
  } fstate_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// 32-bit program counter register with synchronous reset and load enable.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);
  logic [31:0] r_q;

  always_ff @(posedge clock) begin
    if (reset)       r_q <= RESET_PC;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives instruction memory via req/ack, and feeds the IF/ID register
// with either a fetched instruction or a NOP bubble.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          pc_F,
  output logic [31:0]          pc_plus_four_F,
  output logic [31:0]          instruction_F,
  output logic                 valid_F
);

  fstate_e     r_state;
  logic [31:0] r_hold_buf;
  logic [31:0] r_pend_target;

  logic [31:0] w_pc;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_next;
  logic        w_pc_load;
  logic        w_req;
  logic        w_valid;
  logic [31:0] w_instr;

  assign w_tgt = align_pc(redirect_target);

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_pc_load),
    .i_d    (w_pc_next),
    .o_q    (w_pc)
  );

  // Next-PC selection and per-state output decode; redirect outranks stall, stall outranks ack.
  always_comb begin
    w_pc_load = 1'b0;
    w_pc_next = w_pc + 32'd4;
    w_req     = 1'b0;
    w_valid   = 1'b0;
    w_instr   = NOP_INSTR;
    case (r_state)
      FS_FETCH: begin
        w_req = 1'b1;
        if (redirect_valid) begin
          if (imem.imem_ack) begin
            w_pc_load = 1'b1;
            w_pc_next = w_tgt;
          end
        end else if (imem.imem_ack) begin
          w_valid   = 1'b1;
          w_instr   = imem.imem_rdata;
          w_pc_load = !StallF;
        end
      end
      FS_HOLD: begin
        if (redirect_valid) begin
          w_pc_load = 1'b1;
          w_pc_next = w_tgt;
        end else begin
          w_valid   = 1'b1;
          w_instr   = r_hold_buf;
          w_pc_load = !StallF;
        end
      end
      FS_SQUASH: begin
        w_req = 1'b1;
        if (imem.imem_ack) begin
          w_pc_load = 1'b1;
          w_pc_next = redirect_valid ? w_tgt : r_pend_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= FS_FETCH;
      r_hold_buf    <= NOP_INSTR;
      r_pend_target <= 32'h0;
    end else begin
      case (r_state)
        FS_FETCH: begin
          if (redirect_valid) begin
            if (!imem.imem_ack) begin
              r_pend_target <= w_tgt;
              r_state       <= FS_SQUASH;
            end
          end else if (imem.imem_ack && StallF) begin
            r_hold_buf <= imem.imem_rdata;
            r_state    <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (redirect_valid || !StallF) r_state <= FS_FETCH;
        end
        FS_SQUASH: begin
          // The in-flight request cannot be withdrawn; keep it up and drop its data on ack.
          if (redirect_valid) r_pend_target <= w_tgt;
          if (imem.imem_ack)  r_state       <= FS_FETCH;
        end
        default: r_state <= FS_FETCH;
      endcase
    end
  end

  // Reset is synchronous, so the PC register still holds its old value in the reset cycle.
  assign pc_F           = reset ? RESET_PC : w_pc;
  assign pc_plus_four_F = pc_F + 32'd4;
  assign imem.imem_req  = !reset && w_req;
  assign imem.imem_addr = pc_F;
  assign valid_F        = !reset && w_valid;
  assign instruction_F  = valid_F ? w_instr : NOP_INSTR;

endmodule
